// File: rtl/gpio_io_pkg.sv
// Shared types and seven-segment constants for the board GPIO block.
// Segment patterns are active-low {g,f,e,d,c,b,a}.
package gpio_io_pkg;

    typedef enum logic [1:0] {IDLE, SHIFT, LOAD} state_e;

    localparam int BCD_DIGITS = 10;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DIGIT [0:9] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
        7'h12, 7'h02, 7'h78, 7'h00, 7'h10
    };

    // Non-decimal nibbles cannot occur after double-dabble; they fall back to blank.
    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        s = SEG_BLANK;
        for (int i = 0; i < 10; i++) begin
            if (d == 4'(i)) s = SEG_DIGIT[i];
        end
        return s;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential 32-bit double-dabble: one add-3/shift iteration per clock.
// done is high for the single cycle the FSM sits in LOAD, when bcd is final.
module bin2bcd_seq
    import gpio_io_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [31:0]               bin,
    output logic                      busy,
    output logic                      done,
    output logic [4*BCD_DIGITS-1:0]   bcd
);

    localparam int SW = 4*BCD_DIGITS + 32;

    state_e          state_q;
    logic [4:0]      cnt_q;
    logic [SW-1:0]   sh_q;
    logic [SW-1:0]   adj;
    logic            busy_q;
    logic            done_q;

    always_comb begin
        adj = sh_q;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            if (sh_q[32+4*i +: 4] >= 4'd5) adj[32+4*i +: 4] = sh_q[32+4*i +: 4] + 4'd3;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sh_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        sh_q    <= {{(4*BCD_DIGITS){1'b0}}, bin};
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    sh_q  <= {adj[SW-2:0], 1'b0};
                    cnt_q <= cnt_q + 5'd1;
                    if (cnt_q == 5'd31) begin
                        done_q  <= 1'b1;
                        state_q <= LOAD;
                    end
                end
                LOAD: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign bcd  = sh_q[SW-1:32];

endmodule

// File: rtl/gpio_board_io.sv
// Board-side GPIO partner: debounced switches into gpio_in, and gpio_out
// shown in decimal on eight active-low seven-segment digits.
module gpio_board_io
    import gpio_io_pkg::*;
#(
    parameter int NUM_SW          = 18,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter bit BLANK_ZEROS     = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_SW-1:0] sw,
    input  logic [31:0]       gpio_out,
    output logic [31:0]       gpio_in,
    output logic [6:0]        hex0,
    output logic [6:0]        hex1,
    output logic [6:0]        hex2,
    output logic [6:0]        hex3,
    output logic [6:0]        hex4,
    output logic [6:0]        hex5,
    output logic [6:0]        hex6,
    output logic [6:0]        hex7,
    output logic              busy,
    output logic              overflow
);

    localparam int PW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic [NUM_SW-1:0] sync1_q, sync1_d, sync2_q, sync2_d;
    logic [NUM_SW-1:0] samp_q, samp_d, stable_q, stable_d, eq;
    logic [PW-1:0]     presc_q, presc_d;
    logic              tick;
    logic [31:0]       ref_q, ref_d;
    logic [7:0][6:0]   seg_q, seg_d;
    logic              ovf_q, ovf_d;
    logic              start, cvt_busy, cvt_done, lead;
    logic [4*BCD_DIGITS-1:0] bcd;

    bin2bcd_seq u_bcd (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .bin   (gpio_out),
        .busy  (cvt_busy),
        .done  (cvt_done),
        .bcd   (bcd)
    );

    always_comb begin
        tick    = (presc_q == PW'(DEBOUNCE_CYCLES - 1));
        presc_d = tick ? '0 : presc_q + 1'b1;
        sync1_d = sw;
        sync2_d = sync1_q;
        // A bit only moves when two consecutive tick samples agree.
        eq       = ~(sync2_q ^ samp_q);
        samp_d   = tick ? sync2_q : samp_q;
        stable_d = tick ? ((stable_q & ~eq) | (sync2_q & eq)) : stable_q;

        start = !cvt_busy && (gpio_out != ref_q);
        ref_d = start ? gpio_out : ref_q;

        seg_d = seg_q;
        ovf_d = ovf_q;
        lead  = 1'b1;
        if (cvt_done) begin
            for (int k = 7; k >= 0; k--) begin
                lead = lead & (bcd[4*k +: 4] == 4'd0);
                seg_d[k] = (BLANK_ZEROS && k != 0 && lead) ? SEG_BLANK : seg_decode(bcd[4*k +: 4]);
            end
            ovf_d = |bcd[39:32];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            samp_q   <= '0;
            stable_q <= '0;
            presc_q  <= '0;
            ref_q    <= '0;
            seg_q    <= {{7{SEG_BLANK}}, SEG_DIGIT[0]};
            ovf_q    <= 1'b0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            samp_q   <= samp_d;
            stable_q <= stable_d;
            presc_q  <= presc_d;
            ref_q    <= ref_d;
            seg_q    <= seg_d;
            ovf_q    <= ovf_d;
        end
    end

    always_comb begin
        gpio_in             = '0;
        gpio_in[NUM_SW-1:0] = stable_q;
    end

    assign hex0     = seg_q[0];
    assign hex1     = seg_q[1];
    assign hex2     = seg_q[2];
    assign hex3     = seg_q[3];
    assign hex4     = seg_q[4];
    assign hex5     = seg_q[5];
    assign hex6     = seg_q[6];
    assign hex7     = seg_q[7];
    assign busy     = cvt_busy;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_gpio_board_io.sv
// Randomized bench for gpio_board_io with a tick-level debounce model and an
// arithmetic (div/mod) decimal display model.
module tb_gpio_board_io;

    localparam int NSW = 18;
    localparam int DEB = 8;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [NSW-1:0]  sw = '0;
    logic [31:0]     gpio_out = '0;
    logic [31:0]     gpio_in;
    logic [6:0]      hex0, hex1, hex2, hex3, hex4, hex5, hex6, hex7;
    logic            busy, overflow;
    logic [55:0]     hex_all;

    int n_chk  = 0;
    int n_fail = 0;

    logic [6:0] seg_tab [0:9] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                  7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    logic [55:0] rst_hex = {{7{7'h7F}}, 7'h40};

    gpio_board_io #(.NUM_SW(NSW), .DEBOUNCE_CYCLES(DEB), .BLANK_ZEROS(1'b1)) dut (
        .clk(clk), .rst(rst), .sw(sw), .gpio_out(gpio_out), .gpio_in(gpio_in),
        .hex0(hex0), .hex1(hex1), .hex2(hex2), .hex3(hex3),
        .hex4(hex4), .hex5(hex5), .hex6(hex6), .hex7(hex7),
        .busy(busy), .overflow(overflow)
    );

    always #5 clk = ~clk;
    assign hex_all = {hex7, hex6, hex5, hex4, hex3, hex2, hex1, hex0};

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Expected display: lower 8 decimal digits, leading zeros blank except hex0.
    function automatic logic [55:0] exp_hex(input logic [31:0] v);
        longint low, p;
        logic [55:0] r;
        low = longint'(v) % 64'd100000000;
        p = 1;
        r = '0;
        for (int k = 0; k < 8; k++) begin
            if (k > 0 && low < p) r[7*k +: 7] = 7'h7F;
            else r[7*k +: 7] = seg_tab[int'((low / p) % 10)];
            p = p * 10;
        end
        return r;
    endfunction

    // Debounce reference: sw history by cycle, tick every DEB cycles since reset.
    int             m_k;
    logic [NSW-1:0] m_hist [0:3];
    logic [NSW-1:0] m_stable, m_prev, m_synced, m_eq;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_k = 0;
            m_stable = '0;
            m_prev = '0;
        end else begin
            m_synced = (m_k >= 2) ? m_hist[(m_k - 2) % 4] : '0;
            m_hist[m_k % 4] = sw;
            if (m_k % DEB == DEB - 1) begin
                m_eq = ~(m_synced ^ m_prev);
                m_stable = (m_stable & ~m_eq) | (m_synced & m_eq);
                m_prev = m_synced;
            end
            m_k++;
        end
    end

    always @(negedge clk) begin
        if (!rst) chk("gpio_in_model", {32'd0, gpio_in}, {46'd0, m_stable});
    end

    logic [31:0] ref_m = '0;

    task automatic wait_conv(input logic [31:0] v);
        logic [55:0] prev;
        int n;
        prev = hex_all;
        n = 0;
        @(negedge clk);
        chk("hex_hold_while_busy", {8'd0, hex_all}, {8'd0, prev});
        while (busy && n < 100) begin
            n++;
            @(negedge clk);
        end
        chk("busy_cycles", 64'(n), 64'd33);
        chk("display", {8'd0, hex_all}, {8'd0, exp_hex(v)});
        chk("overflow", {63'd0, overflow}, {63'd0, (v >= 32'd100000000)});
        ref_m = v;
    endtask

    task automatic run_conv(input logic [31:0] v_in);
        logic [31:0] v;
        v = (v_in == ref_m) ? (v_in ^ 32'd1) : v_in;
        gpio_out = v;
        wait_conv(v);
    endtask

    initial begin
        int n;
        sw = '1;
        gpio_out = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_gpio_in", {32'd0, gpio_in}, 64'd0);
        chk("rst_hex", {8'd0, hex_all}, {8'd0, rst_hex});
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_overflow", {63'd0, overflow}, 64'd0);
        rst = 1'b0;
        ref_m = '0;
        repeat (10) @(negedge clk);
        chk("no_conv_after_rst", {63'd0, busy}, 64'd0);
        chk("hex_after_rst", {8'd0, hex_all}, {8'd0, rst_hex});
        repeat (20) @(negedge clk);
        chk("sw_all_ones", {32'd0, gpio_in}, {46'd0, sw});

        run_conv(32'd1234);
        run_conv(32'hFFFF_FFFF);
        run_conv(32'd0);
        run_conv(32'd99999999);
        run_conv(32'd100000000);
        run_conv(32'd7);
        for (int i = 0; i < 8; i++) run_conv($urandom);
        for (int i = 0; i < 4; i++) run_conv($urandom_range(0, 99999));

        // Bouncing switch, then a clean final edge to 1.
        sw = '0;
        repeat (40) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            sw[0] = ~sw[0];
            repeat (5) @(negedge clk);
        end
        sw[0] = 1'b1;
        repeat (18) @(negedge clk);
        chk("bounce_settle", {63'd0, gpio_in[0]}, 64'd1);
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            chk("bounce_hold", {63'd0, gpio_in[0]}, 64'd1);
        end

        for (int i = 0; i < 30; i++) begin
            sw = NSW'($urandom);
            repeat ($urandom_range(1, 25)) @(negedge clk);
        end
        repeat (18) @(negedge clk);
        chk("sw_random_settle", {32'd0, gpio_in}, {46'd0, sw});

        // Value changes mid-conversion: first finishes, then restart.
        run_conv(32'd42);
        gpio_out = 32'd1234;
        @(negedge clk);
        repeat (9) @(negedge clk);
        gpio_out = 32'd5678;
        n = 0;
        while (busy && n < 100) begin n++; @(negedge clk); end
        chk("first_display", {8'd0, hex_all}, {8'd0, exp_hex(32'd1234)});
        @(negedge clk);
        chk("restart_busy", {63'd0, busy}, 64'd1);
        n = 0;
        while (busy && n < 100) begin n++; @(negedge clk); end
        chk("restart_busy_cycles", 64'(n), 64'd33);
        chk("second_display", {8'd0, hex_all}, {8'd0, exp_hex(32'd5678)});
        ref_m = 32'd5678;

        // Reset in the middle of a conversion.
        gpio_out = 32'd99;
        repeat (15) @(negedge clk);
        chk("busy_before_rst", {63'd0, busy}, 64'd1);
        rst = 1'b1;
        #1;
        chk("midrst_hex", {8'd0, hex_all}, {8'd0, rst_hex});
        chk("midrst_busy", {63'd0, busy}, 64'd0);
        chk("midrst_overflow", {63'd0, overflow}, 64'd0);
        chk("midrst_gpio_in", {32'd0, gpio_in}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        ref_m = '0;
        wait_conv(32'd99);

        $display("[TB] %0d tests run, %0d failed", n_chk, n_fail);
        $finish;
    end

endmodule
